// File: rtl/item_sprite_drawer.sv
// item_sprite_drawer
//   Once per frame, walks item RAM entries 0..quantity-1 through the rope
//   controller's shared read port and plots every visible item as a filled
//   SPRITE_SIZE x SPRITE_SIZE box on the VGA plot interface.
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   start               1-cycle pulse, begins one frame pass (ignored while busy)
//   quantity[3:0]       number of valid item entries
//   item_data[31:0]     RAM word: [31:23]=x [18:11]=y [3:2]=type [1]=visible [0]=moving
//   draw_stone_flag     high while this block owns the RAM read address
//   draw_index[3:0]     RAM address requested
//   vga_x/vga_y/vga_colour/vga_plot   registered pixel write interface
//   busy, done          pass status; done is a 1-cycle pulse
//
// Build option
//   ITEM_HILITE_EN      when defined, items with moving=1 get a 1-pixel border
//                       in 3'b100; otherwise the moving bit is ignored.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_ADDR  | drive draw_index, take the RAM port, load latency timer
// S_WAIT  | hold the RAM port until item_data is valid
// S_LATCH | capture the item word, then release the RAM port
// S_DRAW  | emit one pixel per cycle in raster order
// S_NEXT  | advance item index or finish
// S_DONE  | one-cycle done pulse

module item_sprite_drawer #(
    parameter int SPRITE_SIZE  = 16,
    parameter int READ_LATENCY = 2,
    parameter int SCREEN_W     = 320,
    parameter int SCREEN_H     = 240
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  quantity,
    input  logic [31:0] item_data,
    output logic        draw_stone_flag,
    output logic [3:0]  draw_index,
    output logic [8:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        busy,
    output logic        done
);

    localparam int PW  = $clog2(SPRITE_SIZE);
    localparam int WCW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
    localparam logic [WCW-1:0] WAIT_LOAD = WCW'(READ_LATENCY - 1);
    localparam logic [PW-1:0]  PIX_LAST  = PW'(SPRITE_SIZE - 1);
    localparam logic [9:0]     X_LIM     = 10'(SCREEN_W);
    localparam logic [9:0]     Y_LIM     = 10'(SCREEN_H);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WAIT, S_LATCH, S_DRAW, S_NEXT, S_DONE
    } state_t;

    state_t         r_state, w_state_next;
    logic [3:0]     r_idx, w_idx_next;
    logic [3:0]     r_qty;
    logic [WCW-1:0] r_wait_cnt, w_wait_next;
    logic [PW-1:0]  r_px, r_py, w_px_next, w_py_next;
    logic [8:0]     r_item_x;
    logic [7:0]     r_item_y;
    logic [1:0]     r_item_type;
    logic           w_start_acc;
    logic           w_load_item;
    logic [4:0]     w_idx_inc5;

    logic           r_flag;
    logic [3:0]     r_draw_index;
    logic [8:0]     r_vga_x;
    logic [7:0]     r_vga_y;
    logic [2:0]     r_vga_colour;
    logic           r_vga_plot;
    logic           r_busy;
    logic           r_done;

    logic           w_in_draw;
    logic           w_flag_next;
    logic [9:0]     w_pix_x;
    logic [9:0]     w_pix_y;
    logic           w_pix_visible;
    logic [2:0]     w_type_colour;
    logic [2:0]     w_pix_colour;

`ifdef ITEM_HILITE_EN
    logic           r_item_moving;
    logic           w_on_border;
    logic           w_unused_bits;
    assign w_unused_bits = ^{item_data[22:19], item_data[10:4]};
    assign w_on_border   = (r_px == '0) || (r_py == '0) ||
                           (r_px == PIX_LAST) || (r_py == PIX_LAST);
`else
    logic           w_unused_bits;
    assign w_unused_bits = ^{item_data[22:19], item_data[10:4], item_data[0]};
`endif

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_idx_inc5  = {1'b0, r_idx} + 5'd1;
    assign w_in_draw   = (r_state == S_DRAW);

    // Box coordinates are summed at 10 bits so boxes hanging off the right or
    // bottom edge are detected instead of wrapping back onto the screen.
    assign w_pix_x       = {1'b0, r_item_x} + 10'(r_px);
    assign w_pix_y       = {2'b0, r_item_y} + 10'(r_py);
    assign w_pix_visible = (w_pix_x < X_LIM) && (w_pix_y < Y_LIM);

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_wait_next  = r_wait_cnt;
        w_px_next    = r_px;
        w_py_next    = r_py;
        w_load_item  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_idx_next   = 4'd0;
                    w_state_next = (quantity == 4'd0) ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: begin
                w_wait_next  = WAIT_LOAD;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_next = S_LATCH;
                end else begin
                    w_wait_next = r_wait_cnt - 1'b1;
                end
            end
            S_LATCH: begin
                w_load_item  = 1'b1;
                w_px_next    = '0;
                w_py_next    = '0;
                w_state_next = item_data[1] ? S_DRAW : S_NEXT;
            end
            S_DRAW: begin
                if (r_px == PIX_LAST) begin
                    w_px_next = '0;
                    w_py_next = r_py + 1'b1;
                    if (r_py == PIX_LAST) begin
                        w_state_next = S_NEXT;
                    end
                end else begin
                    w_px_next = r_px + 1'b1;
                end
            end
            S_NEXT: begin
                // 5-bit compare: quantity=15 stops after index 14 without wrapping.
                if (w_idx_inc5 >= {1'b0, r_qty}) begin
                    w_state_next = S_DONE;
                end else begin
                    w_idx_next   = w_idx_inc5[3:0];
                    w_state_next = S_ADDR;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The flag follows the next state so it is aligned with S_ADDR..S_LATCH
    // and drops on the cycle after the item word is captured.
    assign w_flag_next = (w_state_next == S_ADDR) || (w_state_next == S_WAIT) ||
                         (w_state_next == S_LATCH);

    always_comb begin
        case (r_item_type)
            2'b00:   w_type_colour = 3'b111;
            2'b01:   w_type_colour = 3'b110;
            2'b10:   w_type_colour = 3'b011;
            default: w_type_colour = 3'b101;
        endcase
        w_pix_colour = w_type_colour;
`ifdef ITEM_HILITE_EN
        if (r_item_moving && w_on_border) begin
            w_pix_colour = 3'b100;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_qty         <= '0;
            r_wait_cnt    <= '0;
            r_px          <= '0;
            r_py          <= '0;
            r_item_x      <= '0;
            r_item_y      <= '0;
            r_item_type   <= '0;
`ifdef ITEM_HILITE_EN
            r_item_moving <= 1'b0;
`endif
            r_flag        <= 1'b0;
            r_draw_index  <= '0;
            r_vga_x       <= '0;
            r_vga_y       <= '0;
            r_vga_colour  <= '0;
            r_vga_plot    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_wait_cnt <= w_wait_next;
            r_px       <= w_px_next;
            r_py       <= w_py_next;
            if (w_start_acc) begin
                r_qty <= quantity;
            end
            if (w_load_item) begin
                r_item_x      <= item_data[31:23];
                r_item_y      <= item_data[18:11];
                r_item_type   <= item_data[3:2];
`ifdef ITEM_HILITE_EN
                r_item_moving <= item_data[0];
`endif
            end
            r_flag <= w_flag_next;
            if (w_state_next == S_ADDR) begin
                r_draw_index <= w_idx_next;
            end
            // Clipped pixels still take their slot; only the strobe is suppressed.
            r_vga_plot   <= w_in_draw && w_pix_visible;
            r_vga_x      <= w_in_draw ? w_pix_x[8:0] : 9'd0;
            r_vga_y      <= w_in_draw ? w_pix_y[7:0] : 8'd0;
            r_vga_colour <= w_in_draw ? w_pix_colour : 3'd0;
            if (w_start_acc) begin
                r_busy <= 1'b1;
            end else if (r_state == S_DONE) begin
                r_busy <= 1'b0;
            end
            r_done <= (r_state == S_DONE);
        end
    end

    assign draw_stone_flag = r_flag;
    assign draw_index      = r_draw_index;
    assign vga_x           = r_vga_x;
    assign vga_y           = r_vga_y;
    assign vga_colour      = r_vga_colour;
    assign vga_plot        = r_vga_plot;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule

// File: tb/tb_item_sprite_drawer.sv
// tb_item_sprite_drawer
//   Directed bench for item_sprite_drawer. A small rope-controller model routes
//   the RAM address to draw_index only while draw_stone_flag is high and returns
//   the word two cycles later; otherwise it returns a decoy visible item from
//   entry 15 so that reads outside the flag window show up as stray pixels.

module tb_item_sprite_drawer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [3:0]  quantity;
    logic [31:0] item_data;
    logic        draw_stone_flag;
    logic [3:0]  draw_index;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        busy;
    logic        done;

    item_sprite_drawer dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .quantity        (quantity),
        .item_data       (item_data),
        .draw_stone_flag (draw_stone_flag),
        .draw_index      (draw_index),
        .vga_x           (vga_x),
        .vga_y           (vga_y),
        .vga_colour      (vga_colour),
        .vga_plot        (vga_plot),
        .busy            (busy),
        .done            (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Rope controller + RAM with two cycles of read latency.
    logic [31:0] ram [16];
    logic [31:0] rd_d1 = '0;
    logic [31:0] rd_d2 = '0;
    always @(posedge clock) begin
        rd_d1 <= ram[draw_stone_flag ? draw_index : 4'd15];
        rd_d2 <= rd_d1;
    end
    assign item_data = rd_d2;

    // Monitor: cumulative logs, read by the stimulus thread through base offsets.
    int         n_plot  = 0;
    int         n_flag  = 0;
    int         n_reads = 0;
    int         n_done  = 0;
    logic [8:0] lx [4096];
    logic [7:0] ly [4096];
    logic [2:0] lc [4096];
    logic [3:0] rlog [256];
    logic       prev_flag = 1'b0;

    always @(negedge clock) begin
        if (vga_plot === 1'b1) begin
            if (n_plot < 4096) begin
                lx[n_plot] = vga_x;
                ly[n_plot] = vga_y;
                lc[n_plot] = vga_colour;
            end
            n_plot++;
        end
        if (draw_stone_flag === 1'b1) begin
            n_flag++;
            if (!prev_flag) begin
                if (n_reads < 256) rlog[n_reads] = draw_index;
                n_reads++;
            end
        end
        prev_flag = (draw_stone_flag === 1'b1);
        if (done === 1'b1) n_done++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int x, input int y, input int typ,
                                       input bit vis, input bit mov);
        logic [31:0] w;
        w        = '0;
        w[31:23] = 9'(x);
        w[18:11] = 8'(y);
        w[3:2]   = 2'(typ);
        w[1]     = vis;
        w[0]     = mov;
        return w;
    endfunction

    // Per-pass statistics
    int b_plot, b_flag, b_reads, b_done;
    int s_cnt, s_sumx, s_sumy, s_minx, s_maxx, s_miny, s_maxy, s_oob, s_maxidx;
    int s_col [8];

    task automatic take_base();
        b_plot  = n_plot;
        b_flag  = n_flag;
        b_reads = n_reads;
        b_done  = n_done;
    endtask

    task automatic stats();
        s_cnt = n_plot - b_plot;
        s_sumx = 0; s_sumy = 0; s_oob = 0;
        s_minx = 1000; s_maxx = -1; s_miny = 1000; s_maxy = -1;
        for (int k = 0; k < 8; k++) s_col[k] = 0;
        for (int i = b_plot; i < n_plot && i < 4096; i++) begin
            s_sumx += int'(lx[i]);
            s_sumy += int'(ly[i]);
            if (int'(lx[i]) < s_minx) s_minx = int'(lx[i]);
            if (int'(lx[i]) > s_maxx) s_maxx = int'(lx[i]);
            if (int'(ly[i]) < s_miny) s_miny = int'(ly[i]);
            if (int'(ly[i]) > s_maxy) s_maxy = int'(ly[i]);
            if (lx[i] >= 9'd320 || ly[i] >= 8'd240) s_oob++;
            s_col[lc[i]]++;
        end
        s_maxidx = -1;
        for (int i = b_reads; i < n_reads && i < 256; i++) begin
            if (int'(rlog[i]) > s_maxidx) s_maxidx = int'(rlog[i]);
        end
    endtask

    task automatic run_pass(input string tag, input logic [3:0] q, input int bound,
                            input bit restart_mid);
        int got;
        quantity = q;
        take_base();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        got = 0;
        for (int c = 0; c < bound && got == 0; c++) begin
            @(negedge clock);
            start = (restart_mid && c == 40) ? 1'b1 : 1'b0;
            if (done === 1'b1) got = 1;
        end
        start = 1'b0;
        check_eq({tag, "_done_seen"}, got, 1);
        @(negedge clock);
        #1;
        stats();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        quantity = 4'd0;
        for (int i = 0; i < 16; i++) ram[i] = '0;
        ram[15] = mk(0, 0, 2, 1'b1, 1'b0);
        repeat (3) @(negedge clock);
        #1;
        check_eq("reset_outputs",
                 {draw_stone_flag, draw_index, vga_x, vga_y, vga_colour, vga_plot, busy, done}, 0);
        @(negedge clock) reset = 1'b0;

        // T1: single visible item, type 01
        ram[0] = mk(100, 50, 1, 1'b1, 1'b0);
        run_pass("t1", 4'd1, 1000, 1'b0);
        check_eq("t1_plots", s_cnt, 256);
        check_eq("t1_minx", s_minx, 100);
        check_eq("t1_maxx", s_maxx, 115);
        check_eq("t1_miny", s_miny, 50);
        check_eq("t1_maxy", s_maxy, 65);
        check_eq("t1_sumx", s_sumx, 27520);
        check_eq("t1_sumy", s_sumy, 14720);
        check_eq("t1_col110", s_col[6], 256);
        check_eq("t1_first", {23'd0, lx[b_plot]} * 1000 + {24'd0, ly[b_plot]}, 100050);
        check_eq("t1_second", {23'd0, lx[b_plot+1]} * 1000 + {24'd0, ly[b_plot+1]}, 101050);
        check_eq("t1_row2", {23'd0, lx[b_plot+16]} * 1000 + {24'd0, ly[b_plot+16]}, 100051);
        check_eq("t1_last", {23'd0, lx[b_plot+255]} * 1000 + {24'd0, ly[b_plot+255]}, 115065);
        check_eq("t1_done_cnt", n_done - b_done, 1);
        check_eq("t1_busy_after", busy, 0);

        // T2: middle item invisible; restart attempt mid-pass must be ignored
        ram[0] = mk(10, 20, 0, 1'b1, 1'b0);
        ram[1] = mk(200, 100, 2, 1'b0, 1'b0);
        ram[2] = mk(40, 60, 3, 1'b1, 1'b0);
        run_pass("t2", 4'd3, 3000, 1'b1);
        check_eq("t2_plots", s_cnt, 512);
        check_eq("t2_col111", s_col[7], 256);
        check_eq("t2_col101", s_col[5], 256);
        check_eq("t2_col011", s_col[3], 0);
        check_eq("t2_reads", n_reads - b_reads, 3);
        check_eq("t2_flag_cycles", n_flag - b_flag, 12);
        check_eq("t2_max_idx", s_maxidx, 2);
        check_eq("t2_done_cnt", n_done - b_done, 1);

        // T3: clipping at the bottom-right corner
        ram[0] = mk(310, 230, 0, 1'b1, 1'b0);
        run_pass("t3", 4'd1, 1000, 1'b0);
        check_eq("t3_plots", s_cnt, 100);
        check_eq("t3_oob", s_oob, 0);
        check_eq("t3_maxx", s_maxx, 319);
        check_eq("t3_maxy", s_maxy, 239);
        check_eq("t3_minx", s_minx, 310);
        check_eq("t3_col111", s_col[7], 100);

        // T4: quantity 0 finishes two cycles after start
        quantity = 4'd0;
        take_base();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        #1;
        check_eq("t4_done_c1", done, 0);
        check_eq("t4_busy_c1", busy, 1);
        @(negedge clock);
        #1;
        check_eq("t4_done_c2", done, 1);
        check_eq("t4_busy_c2", busy, 0);
        repeat (3) @(negedge clock);
        #1;
        check_eq("t4_flag_cycles", n_flag - b_flag, 0);
        check_eq("t4_plots", n_plot - b_plot, 0);
        check_eq("t4_done_cnt", n_done - b_done, 1);

        // T5: reset during drawing aborts cleanly, then a full redraw
        ram[0] = mk(100, 50, 1, 1'b1, 1'b0);
        ram[1] = mk(150, 80, 1, 1'b1, 1'b0);
        quantity = 4'd2;
        take_base();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        for (int c = 0; c < 500 && (n_plot - b_plot) < 20; c++) @(negedge clock);
        check_eq("t5_mid_plots", ((n_plot - b_plot) >= 20) ? 1 : 0, 1);
        check_eq("t5_busy_mid", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check_eq("t5_after_reset", {vga_plot, draw_stone_flag, busy, done}, 0);
        reset = 1'b0;
        b_done = n_done;
        repeat (400) @(negedge clock);
        check_eq("t5_no_done", n_done - b_done, 0);
        run_pass("t5b", 4'd2, 2000, 1'b0);
        check_eq("t5_plots", s_cnt, 512);
        check_eq("t5_first", {23'd0, lx[b_plot]} * 1000 + {24'd0, ly[b_plot]}, 100050);
        check_eq("t5_reads", n_reads - b_reads, 2);
        check_eq("t5_first_idx", rlog[b_reads], 0);

        // T6: moving item, type 00
        ram[0] = mk(60, 60, 0, 1'b1, 1'b1);
        run_pass("t6", 4'd1, 1000, 1'b0);
        check_eq("t6_plots", s_cnt, 256);
`ifdef ITEM_HILITE_EN
        check_eq("t6_border", s_col[4], 60);
        check_eq("t6_interior", s_col[7], 196);
`else
        check_eq("t6_border", s_col[4], 0);
        check_eq("t6_interior", s_col[7], 256);
`endif

        // T7: quantity 15, all invisible, index stops at 14
        for (int i = 0; i < 15; i++) ram[i] = mk(i * 10, i * 5, 0, 1'b0, 1'b0);
        run_pass("t7", 4'd15, 2000, 1'b0);
        check_eq("t7_plots", s_cnt, 0);
        check_eq("t7_reads", n_reads - b_reads, 15);
        check_eq("t7_max_idx", s_maxidx, 14);
        check_eq("t7_flag_cycles", n_flag - b_flag, 60);
        check_eq("t7_done_cnt", n_done - b_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
